// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, hides the 1-cycle ROM latency behind a small
// prefetch queue, and flushes on execute redirects. Optional HALT detection: FETCH_HALT_EN.
module fetch_stage #(
    parameter int PC_W   = 10,
    parameter int INST_W = 32,
    parameter int QDEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [INST_W-1:0] rom_q,
    output logic              if_valid,
    output logic [INST_W-1:0] if_IR,
    output logic [PC_W-1:0]   if_PC,
    output logic              halted
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1) + 1;
    localparam logic [CW-1:0] QD   = CW'(QDEPTH);
    localparam logic [PW-1:0] PMAX = PW'(QDEPTH - 1);

    logic [PC_W-1:0]                pc;
    logic                           inflight;
    logic [PC_W-1:0]                inflight_pc;
    logic [QDEPTH-1:0][INST_W-1:0]  q_ir;
    logic [QDEPTH-1:0][PC_W-1:0]    q_pc;
    logic [PW-1:0]                  head, tail;
    logic [CW-1:0]                  count;
    logic                           pop, push, issue, halt_seen, halt_r;
    logic [CW-1:0]                  occ, lim;

    assign if_valid = (count != '0);
    assign if_IR    = if_valid ? q_ir[head] : '0;
    assign if_PC    = if_valid ? q_pc[head] : '0;
    assign rom_addr = pc;
    assign halted   = halt_r;

    // Credit check counts the pop on this edge so a released stall refills immediately.
    assign pop   = if_valid & ~stall & ~redirect_en;
    assign push  = inflight & ~redirect_en;
    assign occ   = count + CW'(inflight);
    assign lim   = QD + CW'(pop);
    assign issue = ~redirect_en & ~halt_r & (occ < lim);

`ifdef FETCH_HALT_EN
    assign halt_seen = push && (rom_q[INST_W-1 -: 6] == 6'b111111);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            halt_r <= 1'b0;
        else if (redirect_en)
            halt_r <= 1'b0;
        else if (halt_seen)
            halt_r <= 1'b1;
    end
`else
    assign halt_seen = 1'b0;
    assign halt_r    = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
        end else if (redirect_en) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (issue) begin
                pc          <= pc + PC_W'(1);
                inflight_pc <= pc;
            end
            // A fetch launched alongside the HALT capture is dropped.
            inflight <= issue & ~halt_seen;
            if (push)
                tail <= (tail == PMAX) ? '0 : tail + PW'(1);
            if (pop)
                head <= (head == PMAX) ? '0 : head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue payload needs no reset: the outputs are masked by if_valid.
    always_ff @(posedge clock) begin
        if (push) begin
            q_ir[tail] <= rom_q;
            q_pc[tail] <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for streaming/stall/redirect/wrap,
// hand sequences for async reset and (with FETCH_HALT_EN) HALT.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_en;
    logic [9:0]  redirect_pc;
    logic [9:0]  rom_addr;
    logic [31:0] rom_q;
    logic        if_valid;
    logic [31:0] if_IR;
    logic [9:0]  if_PC;
    logic        halted;
    logic        halt_rom;

    int errors = 0;
    int checks = 0;

    fetch_stage dut (
        .clock(clock), .reset(reset), .stall(stall),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .rom_addr(rom_addr), .rom_q(rom_q),
        .if_valid(if_valid), .if_IR(if_IR), .if_PC(if_PC), .halted(halted)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [9:0] a);
        if (halt_rom && a == 10'd4) return 32'hFC00_0000;
        return {22'd0, a} + 32'h100;
    endfunction

    always @(posedge clock) rom_q <= rom_word(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [9:0] p, input logic [9:0] a);
        chk({tag, " valid"}, 32'(if_valid), 32'(v));
        chk({tag, " pc"},    32'(if_PC),    v ? 32'(p) : 32'h0);
        chk({tag, " ir"},    if_IR,         v ? 32'(p) + 32'h100 : 32'h0);
        chk({tag, " addr"},  32'(rom_addr), 32'(a));
    endtask

    typedef struct {
        logic       stall;
        logic       redir;
        logic [9:0] rpc;
        logic       valid;
        logic [9:0] pc;
        logic [9:0] addr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input logic r, input logic [9:0] rp,
                       input logic v, input logic [9:0] p, input logic [9:0] a);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.valid = v; t.pc = p; t.addr = a;
        vq.push_back(t);
    endtask

    task automatic edge_chk();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; halt_rom = 1'b0;

        // streaming from reset
        add(0,0,0,   0,10'h000,10'h001);
        add(0,0,0,   1,10'h000,10'h002);
        add(0,0,0,   1,10'h001,10'h003);
        add(0,0,0,   1,10'h002,10'h004);
        add(0,0,0,   1,10'h003,10'h005);
        add(0,0,0,   1,10'h004,10'h006);
        add(0,0,0,   1,10'h005,10'h007);
        // 3-cycle stall at PC 5, then release
        add(1,0,0,   1,10'h005,10'h007);
        add(1,0,0,   1,10'h005,10'h007);
        add(1,0,0,   1,10'h005,10'h007);
        add(0,0,0,   1,10'h006,10'h008);
        add(0,0,0,   1,10'h007,10'h009);
        add(0,0,0,   1,10'h008,10'h00A);
        // redirect with a fetch in flight
        add(0,1,10'h3F0, 0,10'h000,10'h3F0);
        add(0,0,0,   0,10'h000,10'h3F1);
        add(0,0,0,   1,10'h3F0,10'h3F2);
        add(0,0,0,   1,10'h3F1,10'h3F3);
        // fill queue, then redirect+stall together
        add(1,0,0,   1,10'h3F1,10'h3F3);
        add(1,0,0,   1,10'h3F1,10'h3F3);
        add(1,1,10'h3FF, 0,10'h000,10'h3FF);
        add(0,0,0,   0,10'h000,10'h000);
        add(0,0,0,   1,10'h3FF,10'h001);
        add(0,0,0,   1,10'h000,10'h002);
        add(0,0,0,   1,10'h001,10'h003);
        // redirect to 0x3FF with stall=0: PC wrap
        add(0,1,10'h3FF, 0,10'h000,10'h3FF);
        add(0,0,0,   0,10'h000,10'h000);
        add(0,0,0,   1,10'h3FF,10'h001);
        add(0,0,0,   1,10'h000,10'h002);
        add(0,0,0,   1,10'h001,10'h003);
        // stall while empty does not block fetch
        add(0,1,10'h010, 0,10'h000,10'h010);
        add(1,0,0,   0,10'h000,10'h011);
        add(1,0,0,   1,10'h010,10'h012);
        add(1,0,0,   1,10'h010,10'h012);
        add(0,0,0,   1,10'h011,10'h013);

        #1;
        chk_out("reset", 1'b0, 10'h0, 10'h0);
        chk("reset halted", 32'(halted), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            stall = vq[i].stall; redirect_en = vq[i].redir; redirect_pc = vq[i].rpc;
            edge_chk();
            chk_out($sformatf("v%0d", i), vq[i].valid, vq[i].pc, vq[i].addr);
            chk($sformatf("v%0d halted", i), 32'(halted), 32'h0);
        end
        redirect_en = 1'b0;

        // async reset mid-stream with a full queue
        stall = 1'b1;
        edge_chk();
        edge_chk();
        chk_out("full before reset", 1'b1, 10'h011, 10'h013);
        @(negedge clock);
        #2 reset = 1'b1;
        #1 chk_out("async reset", 1'b0, 10'h0, 10'h0);
        @(negedge clock);
        reset = 1'b0; stall = 1'b0;
        edge_chk(); chk_out("rst e1", 1'b0, 10'h000, 10'h001);
        edge_chk(); chk_out("rst e2", 1'b1, 10'h000, 10'h002);
        edge_chk(); chk_out("rst e3", 1'b1, 10'h001, 10'h003);

`ifdef FETCH_HALT_EN
        @(negedge clock);
        reset = 1'b1; halt_rom = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int e = 1; e <= 5; e++) edge_chk();
        chk_out("pre halt", 1'b1, 10'h003, 10'h005);
        edge_chk();
        chk("halt set", 32'(halted), 32'h1);
        chk("halt pc", 32'(if_PC), 32'h4);
        chk("halt ir", if_IR, 32'hFC00_0000);
        begin
            logic [9:0] frozen;
            frozen = rom_addr;
            edge_chk();
            chk("halt drain valid", 32'(if_valid), 32'h0);
            edge_chk();
            chk("halt addr hold", 32'(rom_addr), 32'(frozen));
            chk("halt hold", 32'(halted), 32'h1);
        end
        redirect_en = 1'b1; redirect_pc = 10'h000;
        edge_chk();
        redirect_en = 1'b0;
        chk("halt cleared", 32'(halted), 32'h0);
        chk_out("halt redir", 1'b0, 10'h0, 10'h000);
        edge_chk(); chk_out("halt restart e1", 1'b0, 10'h000, 10'h001);
        edge_chk(); chk_out("halt restart e2", 1'b1, 10'h000, 10'h002);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits between the PC / synchronous instruction ROM and the decode register.
- Owns the PC and drives the ROM address. Absorbs the ROM's 1-cycle read latency with a small prefetch queue.
- Presents {instruction, PC} pairs to decode under a stall/valid handshake.
- Handles jump/beq redirects from execute by flushing everything in flight.

Parameters:
- PC_W, 10, PC / ROM address width (word addressed).
- INST_W, 32, instruction width.
- QDEPTH, 2, prefetch queue entries. Minimum 2 to sustain one fetch per cycle.

Ports:
- clock  input  1  pipeline clock (divided board clock).
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  decode cannot accept this cycle (hazard unit).
- redirect_en  input  1  jump/beq taken in execute.
- redirect_pc  input  PC_W  target PC for redirect.
- rom_addr  output  PC_W  address to synchronous ROM; equals the PC register.
- rom_q  input  INST_W  ROM data, valid one clock after the address is sampled.
- if_valid  output  1  queue head holds a valid instruction.
- if_IR  output  INST_W  head instruction; 0 (NOP bubble) when if_valid=0.
- if_PC  output  PC_W  PC of head instruction; 0 when if_valid=0.
- halted  output  1  fetch stopped by HALT (see optional feature).

Behaviour:
Reset:
- Asynchronous, on reset=1: PC=0, queue empty, in-flight flag cleared, halted=0.
- Outputs during reset: if_valid=0, if_IR=0, if_PC=0, rom_addr=0.

Definitions:
- pop = if_valid & ~stall & ~redirect_en.
- issue = ~redirect_en & ~halted & (count + inflight - pop < QDEPTH).

Each posedge:
- Issue: on issue, the ROM samples rom_addr (=PC), inflight<=1, inflight_pc<=PC, PC<=PC+1.
- Capture: if inflight=1 at the edge, {inflight_pc, rom_q} is written to the queue tail. inflight clears unless a new issue occurs on the same edge.
- Simultaneous push and pop are legal; count is unchanged.
- Redirect (highest priority, over stall and issue):
  - PC<=redirect_pc; queue emptied; inflight cleared, and its data is discarded, never enqueued.
  - No issue on the redirect edge. redirect_pc is issued on the following edge.
  - if_valid=0 the cycle after the redirect.

Latency:
- First edge after reset release issues address 0.
- Next edge enqueues it; if_valid=1 from then on.
- Redirect to first valid target instruction: 2 edges.

Throughput:
- 1 instruction/cycle with stall=0 and QDEPTH>=2.

Boundaries:
- Queue full with stall=1: no issue, PC holds; if_IR/if_PC stable.
- Stall released: head pops the same edge; issue resumes the same edge (credit counts the pop).
- PC wraps modulo 2^PC_W: 1023 -> 0, no flag.
- Queue pointers wrap modulo QDEPTH.
- stall while if_valid=0 has no effect.

Outputs:
- if_IR/if_PC come combinationally from the queue head registers.
- No ROM-to-output combinational path.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - An instruction with opcode [31:26]=6'b111111 that is enqueued sets halted=1 on that edge.
  - Further issue stops. The HALT word and earlier entries still drain normally.
  - redirect_en or reset clears halted.
  - An in-flight fetch issued before the HALT was seen is discarded when the HALT is enqueued.
- Undefined: halted is tied 0; opcode 111111 is treated as an ordinary instruction.

Test Plan:
1. Reset, release, ROM[n]=n+0x100, stall=0 -> edge 2 after release: if_valid=1, if_IR=0x100, if_PC=0. Then one instruction per edge with PC 1, 2, 3...
2. stall=1 for 3 cycles while streaming at PC 5 -> if_PC holds 5, queue fills to 2, rom_addr freezes at 7. On release, PCs 5, 6, 7 are delivered on consecutive edges with no gap or duplicate.
3. redirect_en=1, redirect_pc=0x3F0, with a full queue and a fetch in flight -> next cycle if_valid=0. if_PC=0x3F0 appears 2 edges later; the old PCs never appear.
4. redirect_en and stall asserted together -> redirect wins: queue flushed, target delivered as in case 3.
5. Redirect to 0x3FF with stall=0 -> if_PC sequence 0x3FF, 0x000, 0x001 (wrap-around).
6. (FETCH_HALT_EN) ROM[4]=0xFC000000 -> halted=1 when it is enqueued, rom_addr stops advancing; PC 4 is still delivered. redirect_pc=0 clears halted and fetching restarts at 0.
7. Assert reset mid-stream with a full queue -> all outputs 0 immediately (asynchronous); after release, behaviour matches case 1.
